// File: rtl/bitstuff_nrzi_tx.sv
// Serial transmit back end: SYNC prefix, zero stuffing after a run of ones, NRZI, EOP on dp/dm.
// Optional build macro BITSTUFF_NRZI_EN enables NRZI; without it the line carries the stuffed bits directly.
module bitstuff_nrzi_tx #(
    parameter int SYNC_LEN  = 8,
    parameter int STUFF_RUN = 6,
    parameter int EOP_SE0   = 2
) (
    input  logic clk,
    input  logic rst_L,
    input  logic inb,
    input  logic in_sending,
    output logic pause,
    output logic dp,
    output logic dm,
    output logic eop_done
);
    localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN - 1);
    localparam logic [3:0] EOP_LAST  = 4'(EOP_SE0 - 1);
    localparam logic [2:0] RUN_MAX   = 3'(STUFF_RUN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_STUFF = 3'd3,
        ST_EOP0  = 3'd4,
        ST_EOPJ  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        LINE_HOLD = 2'd0,
        LINE_J    = 2'd1,
        LINE_SE0  = 2'd2,
        LINE_BIT  = 2'd3
    } line_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] bit_cnt_r;
    logic [3:0] bit_cnt_next_s;
    logic [2:0] ones_r;
    logic [2:0] ones_next_s;
    line_t      line_mode_s;
    logic       tx_bit_s;
    logic       line_bit_s;
    logic       eop_pulse_s;

    // Next state, counters, encoder handshake and what the line should do this cycle
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        ones_next_s    = ones_r;
        pause          = 1'b0;
        line_mode_s    = LINE_HOLD;
        tx_bit_s       = 1'b0;
        eop_pulse_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pause       = in_sending;
                line_mode_s = LINE_J;
                if (in_sending) begin
                    state_next_s   = ST_SYNC;
                    bit_cnt_next_s = 4'd0;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_SYNC: begin
                pause       = 1'b1;
                line_mode_s = LINE_BIT;
                tx_bit_s    = (bit_cnt_r == SYNC_LAST);
                if (bit_cnt_r == SYNC_LAST) begin
                    // the closing SYNC one already counts toward the stuffing run
                    state_next_s   = ST_DATA;
                    bit_cnt_next_s = 4'd0;
                    ones_next_s    = 3'd1;
                end else begin
                    bit_cnt_next_s = bit_cnt_r + 4'd1;
                end
            end
            ST_DATA: begin
                bit_cnt_next_s = 4'd0;
                if (in_sending) begin
                    line_mode_s = LINE_BIT;
                    tx_bit_s    = inb;
                    if (inb) begin
                        ones_next_s = (ones_r >= RUN_MAX) ? RUN_MAX : ones_r + 3'd1;
                    end else begin
                        ones_next_s = 3'd0;
                    end
                    if (ones_next_s == RUN_MAX) begin
                        state_next_s = ST_STUFF;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_EOP0;
                end
            end
            ST_STUFF: begin
                pause          = 1'b1;
                line_mode_s    = LINE_BIT;
                tx_bit_s       = 1'b0;
                ones_next_s    = 3'd0;
                bit_cnt_next_s = 4'd0;
                if (in_sending) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_EOP0;
                end
            end
            ST_EOP0: begin
                line_mode_s = LINE_SE0;
                if (bit_cnt_r == EOP_LAST) begin
                    state_next_s   = ST_EOPJ;
                    bit_cnt_next_s = 4'd0;
                end else begin
                    bit_cnt_next_s = bit_cnt_r + 4'd1;
                end
            end
            ST_EOPJ: begin
                line_mode_s  = LINE_J;
                eop_pulse_s  = 1'b1;
                state_next_s = ST_IDLE;
                ones_next_s  = 3'd0;
            end
            default: begin
                state_next_s   = ST_IDLE;
                bit_cnt_next_s = 4'd0;
                ones_next_s    = 3'd0;
            end
        endcase
    end

`ifdef BITSTUFF_NRZI_EN
    logic level_r;
    logic level_next_s;

    // NRZI: a transmitted zero toggles the level, J forces it back to 1
    always_comb begin
        level_next_s = level_r;
        if (line_mode_s == LINE_J) begin
            level_next_s = 1'b1;
        end else if ((line_mode_s == LINE_BIT) && !tx_bit_s) begin
            level_next_s = ~level_r;
        end else begin
            level_next_s = level_r;
        end
    end

    // NRZI level register
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            level_r <= 1'b1;
        end else begin
            level_r <= level_next_s;
        end
    end

    assign line_bit_s = level_next_s;
`else
    assign line_bit_s = tx_bit_s;
`endif

    // State, counters and registered line outputs
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            ones_r    <= 3'd0;
            dp        <= 1'b1;
            dm        <= 1'b0;
            eop_done  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            ones_r    <= ones_next_s;
            eop_done  <= eop_pulse_s;
            case (line_mode_s)
                LINE_J: begin
                    dp <= 1'b1;
                    dm <= 1'b0;
                end
                LINE_SE0: begin
                    dp <= 1'b0;
                    dm <= 1'b0;
                end
                LINE_BIT: begin
                    dp <= line_bit_s;
                    dm <= ~line_bit_s;
                end
                default: begin
                    dp <= dp;
                    dm <= dm;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bitstuff_nrzi_tx.sv
// Self-checking bench for bitstuff_nrzi_tx: an encoder-like driver plus a packet-level line model.
module tb_bitstuff_nrzi_tx;
    localparam int SYNC_LEN  = 8;
    localparam int STUFF_RUN = 6;
    localparam int EOP_SE0   = 2;

    logic clk = 1'b0;
    logic rst_L;
    logic inb;
    logic in_sending;
    logic pause;
    logic dp;
    logic dm;
    logic eop_done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bitstuff_nrzi_tx #(
        .SYNC_LEN (SYNC_LEN),
        .STUFF_RUN(STUFF_RUN),
        .EOP_SE0  (EOP_SE0)
    ) dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .inb       (inb),
        .in_sending(in_sending),
        .pause     (pause),
        .dp        (dp),
        .dm        (dm),
        .eop_done  (eop_done)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_line(input string tag);
        check({tag, ".dp"}, dp, 1'b1);
        check({tag, ".dm"}, dm, 1'b0);
        check({tag, ".eop"}, eop_done, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_sending = 1'b0;
            inb        = 1'($urandom);
            #1;
            check("idle.pause", pause, 1'b0);
            @(posedge clk);
            #1;
            check_idle_line("idle");
        end
    endtask

    // Sends len bits of 'bits' LSB-first; abort_c >= 0 applies reset before edge abort_c.
    task automatic run_packet(input logic [31:0] bits, input int len, input int abort_c);
        bit   sbits[$];
        bit   ovh[$];
        bit   line[$];
        int   run;
        int   n;
        int   last_c;
        int   k;
        int   ptr;
        bit   tail_stuff;
        logic lvl;
        logic ep;
        logic ed;
        logic em;
        logic ee;
        logic prev_dp;
        logic prev_dm;

        for (int i = 0; i < SYNC_LEN; i++) begin
            sbits.push_back(i == SYNC_LEN - 1);
            ovh.push_back(1'b1);
        end
        run = 1;
        for (int i = 0; i < len; i++) begin
            sbits.push_back(bits[i]);
            ovh.push_back(1'b0);
            run = bits[i] ? run + 1 : 0;
            if (run == STUFF_RUN) begin
                sbits.push_back(1'b0);
                ovh.push_back(1'b1);
                run = 0;
            end
        end
        lvl = 1'b1;
        foreach (sbits[i]) begin
`ifdef BITSTUFF_NRZI_EN
            if (!sbits[i]) lvl = ~lvl;
            line.push_back(lvl);
`else
            line.push_back(sbits[i]);
`endif
        end
        n          = sbits.size();
        tail_stuff = ovh[n-1];
        last_c     = tail_stuff ? n + EOP_SE0 + 1 : n + EOP_SE0 + 2;
        ptr        = 0;
        prev_dp    = 1'b1;
        prev_dm    = 1'b0;

        for (int c = 0; c <= last_c; c++) begin
            in_sending = (ptr < len);
            inb        = in_sending ? bits[ptr] : 1'($urandom);
            ee         = 1'b0;
            if (c == 0) begin
                ep = 1'b1;
                ed = 1'b1;
                em = 1'b0;
            end else if (c <= n) begin
                ep = ovh[c-1];
                ed = line[c-1];
                em = ~line[c-1];
            end else begin
                k  = tail_stuff ? c - n : c - n - 1;
                ep = 1'b0;
                if (k == 0) begin
                    ed = prev_dp;
                    em = prev_dm;
                end else if (k <= EOP_SE0) begin
                    ed = 1'b0;
                    em = 1'b0;
                end else begin
                    ed = 1'b1;
                    em = 1'b0;
                    ee = 1'b1;
                end
            end
            #1;
            check("pkt.pause", pause, ep);
            if (c == abort_c) begin
                rst_L = 1'b0;
                @(posedge clk);
                #1;
                check_idle_line("abort");
                in_sending = 1'b0;
                #1;
                check("abort.pause", pause, 1'b0);
                rst_L = 1'b1;
                return;
            end
            @(posedge clk);
            if (!ep && in_sending) ptr++;
            #1;
            check("pkt.dp", dp, ed);
            check("pkt.dm", dm, em);
            check("pkt.eop", eop_done, ee);
            prev_dp = ed;
            prev_dm = em;
        end
        in_sending = 1'b0;
    endtask

    initial begin
        rst_L      = 1'b0;
        in_sending = 1'b0;
        inb        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_idle_line("reset");
            check("reset.pause", pause, 1'b0);
        end
        rst_L = 1'b1;
        idle_cycles(1);

        run_packet(32'h0000_0000, 4, -1);   // SYNC only followed by zeros
        idle_cycles(2);
        run_packet(32'h0000_00FF, 8, -1);   // stuff after the fifth data one
        idle_cycles(1);
        run_packet(32'h0000_000F, 8, -1);
        run_packet(32'h0000_007E, 7, -1);   // six ones end the packet: tail stuff
        run_packet(32'h0000_001F, 5, -1);   // SYNC one plus five ones also ends in a stuff
        idle_cycles(1);
        run_packet(32'h0000_0FFF, 12, 12);  // reset during DATA
        run_packet(32'h0000_0FFF, 12, -1);
        idle_cycles(1);

        for (int p = 0; p < 30; p++) begin
            run_packet($urandom | $urandom, int'($urandom_range(1, 32)), -1);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
